alarm_ctrl: RTL
===============

// Module: alarm_ctrl
// PURPOSE
//  Alarm scheduler for the digital clock. Holds a programmable alarm time (HH:MM),
//  compares it with the running time from the timekeeping core once per second,
//  and sequences the ring/snooze/stop state machine that drives the buzzer.
//  Sits beside the timer and the setting block; its alarm registers feed the display.
// PARAMETERS
//  RING_SECONDS    60   ticks a ring lasts before it stops by itself
//  SNOOZE_SECONDS  300  ticks spent in snooze before ringing again
//  MAX_SNOOZE      3    snoozes allowed per alarm event
// PORTS
//  clk            in   1  100 MHz system clock
//  reset          in   1  asynchronous, active-high
//  tick_1hz       in   1  one-clk-cycle pulse per second, synchronous to clk
//  hours          in   6  current time, 0..23
//  minutes        in   6  current time, 0..59
//  seconds        in   6  current time, 0..59
//  alarm_en       in   1  level; 0 disables the alarm
//  set_alarm      in   1  level; 1 = alarm-time edit mode
//  sel_field      in   1  0 = edit minutes, 1 = edit hours
//  inc, dec       in   1  one-cycle pulses (already debounced and edge-detected)
//  stop, snooze   in   1  one-cycle pulses
//  alarm_hours    out  6  programmed alarm hour
//  alarm_minutes  out  6  programmed alarm minute
//  ringing        out  1  1 while in RINGING
//  buzzer         out  1  ringing AND beep_phase
//  snooze_active  out  1  1 while in SNOOZE
//  state          out  2  00 DISABLED, 01 ARMED, 10 RINGING, 11 SNOOZE
// BEHAVIOUR
//  Reset: state=DISABLED, alarm_hours=0, alarm_minutes=0, all counters=0, beep_phase=0,
//   all outputs 0. All outputs are registered; response appears 1 clk after the cause.
//  Edit: only while set_alarm=1. inc/dec step the selected field by 1. Hours wrap 23->0
//   and 0->23; minutes wrap 59->0 and 0->59. inc and dec together: no change.
//   inc/dec are ignored while set_alarm=0.
//  State transitions, in priority order, evaluated every clk:
//   1. alarm_en=0 -> DISABLED from any state; snooze_cnt cleared.
//   2. DISABLED with alarm_en=1 -> ARMED.
//   3. set_alarm=1 in RINGING or SNOOZE -> ARMED; snooze_cnt cleared.
//   4. ARMED: tick_1hz & set_alarm=0 & hours==alarm_hours & minutes==alarm_minutes
//      & seconds==0 -> RINGING; ring_cnt=0; beep_phase=1.
//   5. RINGING: stop -> ARMED (stop wins over a simultaneous snooze).
//      snooze & snooze_cnt<MAX_SNOOZE -> SNOOZE; snooze_cnt+1; wait_cnt=0.
//      snooze & snooze_cnt==MAX_SNOOZE -> handled as stop.
//      On a tick: ring_cnt+1 and beep_phase toggles. When ring_cnt reaches
//      RING_SECONDS-1 and a tick arrives -> ARMED.
//   6. SNOOZE: stop -> ARMED. On a tick: wait_cnt+1. When wait_cnt reaches
//      SNOOZE_SECONDS-1 and a tick arrives -> RINGING; ring_cnt=0; beep_phase=1.
//  snooze_cnt clears on every entry to ARMED or DISABLED.
//  The trigger requires seconds==0, so a stop within the match minute does not
//   re-trigger. The alarm time is compared live; an edit made while ARMED takes effect
//   at the next tick.
//  Counters use $clog2 of their parameter and saturate at the terminal value; they
//   never wrap.
//  Reset mid-ring or mid-snooze returns to DISABLED at once and clears the alarm time.
// TESTING
//  1. Reset, alarm_en=1 -> state 00 then 01 next clk; alarm_hours/alarm_minutes=0.
//  2. set_alarm=1, sel_field=1, 3x dec from 0 -> alarm_hours=21; sel_field=0, inc from 59
//     -> alarm_minutes=0; inc and dec together -> no change.
//  3. Alarm 07:30, drive time 07:29:59 -> 07:30:00 with a tick -> ringing=1 next clk;
//     buzzer toggles each tick; with no input, back to ARMED after 60 ticks.
//  4. Ringing, snooze -> SNOOZE; after 300 ticks -> RINGING. Repeat: the 4th snooze
//     behaves as stop -> ARMED.
//  5. Ringing, stop and snooze in the same clk -> ARMED, snooze_cnt=0; further ticks in
//     minute 07:30 do not re-trigger.
//  6. SNOOZE with alarm_en=0 -> DISABLED next clk. Async reset mid-RINGING -> all
//     outputs 0 immediately.

Source files
------------

// File: rtl/alarm_ctrl_if.sv
// Signal bundle between the alarm scheduler, the timekeeping core and the setting UI.
// The master side drives time, controls and buttons; the slave side is the scheduler.
interface alarm_ctrl_if;
    logic       tick_1hz;
    logic [5:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       alarm_en;
    logic       set_alarm;
    logic       sel_field;
    logic       inc;
    logic       dec;
    logic       stop;
    logic       snooze;
    logic [5:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic       ringing;
    logic       buzzer;
    logic       snooze_active;
    logic [1:0] state;

    modport master (
        output tick_1hz, hours, minutes, seconds,
        output alarm_en, set_alarm, sel_field, inc, dec, stop, snooze,
        input  alarm_hours, alarm_minutes, ringing, buzzer, snooze_active, state
    );

    modport slave (
        input  tick_1hz, hours, minutes, seconds,
        input  alarm_en, set_alarm, sel_field, inc, dec, stop, snooze,
        output alarm_hours, alarm_minutes, ringing, buzzer, snooze_active, state
    );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm scheduler: programmable HH:MM alarm, once-per-second match against the running
// time, and the ring/snooze/stop sequencer driving the buzzer. All outputs are registered.
module alarm_ctrl #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic        clk,
    input  logic        reset,
    alarm_ctrl_if.slave bus
);

    localparam int RING_W = (RING_SECONDS > 1)   ? $clog2(RING_SECONDS)   : 1;
    localparam int WAIT_W = (SNOOZE_SECONDS > 1) ? $clog2(SNOOZE_SECONDS) : 1;
    localparam int SNZ_W  = (MAX_SNOOZE > 0)     ? $clog2(MAX_SNOOZE + 1) : 1;

    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SECONDS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SNOOZE_SECONDS - 1);
    localparam logic [SNZ_W-1:0]  SNZ_MAX   = SNZ_W'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        DISABLED = 2'b00,
        ARMED    = 2'b01,
        RINGING  = 2'b10,
        SNOOZE   = 2'b11
    } state_t;

    state_t            state_q, state_n;
    logic [RING_W-1:0] ring_cnt_q, ring_cnt_n;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_n;
    logic [SNZ_W-1:0]  snooze_cnt_q, snooze_cnt_n;
    logic              beep_q, beep_n;
    logic [5:0]        alarm_hours_q, alarm_hours_n;
    logic [5:0]        alarm_minutes_q, alarm_minutes_n;
    logic              ringing_q, buzzer_q, snooze_active_q;

    logic step_up;
    logic step_dn;
    logic trigger;

    // Pressing inc and dec together cancels out.
    assign step_up = bus.set_alarm & bus.inc & ~bus.dec;
    assign step_dn = bus.set_alarm & bus.dec & ~bus.inc;

    always_comb begin
        alarm_hours_n   = alarm_hours_q;
        alarm_minutes_n = alarm_minutes_q;
        if (bus.sel_field) begin
            if (step_up)
                alarm_hours_n = (alarm_hours_q == 6'd23) ? 6'd0 : alarm_hours_q + 6'd1;
            else if (step_dn)
                alarm_hours_n = (alarm_hours_q == 6'd0) ? 6'd23 : alarm_hours_q - 6'd1;
        end else begin
            if (step_up)
                alarm_minutes_n = (alarm_minutes_q == 6'd59) ? 6'd0 : alarm_minutes_q + 6'd1;
            else if (step_dn)
                alarm_minutes_n = (alarm_minutes_q == 6'd0) ? 6'd59 : alarm_minutes_q - 6'd1;
        end
    end

    // Requiring seconds==0 keeps a stopped alarm from re-firing within its own minute.
    assign trigger = bus.tick_1hz & ~bus.set_alarm &
                     (bus.hours == alarm_hours_q) &
                     (bus.minutes == alarm_minutes_q) &
                     (bus.seconds == 6'd0);

    always_comb begin
        state_n      = state_q;
        ring_cnt_n   = ring_cnt_q;
        wait_cnt_n   = wait_cnt_q;
        snooze_cnt_n = snooze_cnt_q;
        beep_n       = beep_q;

        if (!bus.alarm_en) begin
            state_n      = DISABLED;
            snooze_cnt_n = '0;
        end else begin
            unique case (state_q)
                DISABLED: begin
                    state_n      = ARMED;
                    snooze_cnt_n = '0;
                end
                ARMED: begin
                    if (trigger) begin
                        state_n    = RINGING;
                        ring_cnt_n = '0;
                        beep_n     = 1'b1;
                    end
                end
                RINGING: begin
                    // A snooze past the allowance is treated exactly like stop.
                    if (bus.set_alarm || bus.stop ||
                        (bus.snooze && snooze_cnt_q >= SNZ_MAX)) begin
                        state_n      = ARMED;
                        snooze_cnt_n = '0;
                    end else if (bus.snooze) begin
                        state_n      = SNOOZE;
                        snooze_cnt_n = snooze_cnt_q + 1'b1;
                        wait_cnt_n   = '0;
                    end else if (bus.tick_1hz) begin
                        if (ring_cnt_q == RING_LAST) begin
                            state_n      = ARMED;
                            snooze_cnt_n = '0;
                        end else begin
                            ring_cnt_n = ring_cnt_q + 1'b1;
                            beep_n     = ~beep_q;
                        end
                    end
                end
                SNOOZE: begin
                    if (bus.set_alarm || bus.stop) begin
                        state_n      = ARMED;
                        snooze_cnt_n = '0;
                    end else if (bus.tick_1hz) begin
                        if (wait_cnt_q == WAIT_LAST) begin
                            state_n    = RINGING;
                            ring_cnt_n = '0;
                            beep_n     = 1'b1;
                        end else begin
                            wait_cnt_n = wait_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_n = DISABLED;
            endcase
        end
    end

    // Outputs are decoded from next-state values so they appear one clk after the cause.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= DISABLED;
            ring_cnt_q      <= '0;
            wait_cnt_q      <= '0;
            snooze_cnt_q    <= '0;
            beep_q          <= 1'b0;
            alarm_hours_q   <= 6'd0;
            alarm_minutes_q <= 6'd0;
            ringing_q       <= 1'b0;
            buzzer_q        <= 1'b0;
            snooze_active_q <= 1'b0;
        end else begin
            state_q         <= state_n;
            ring_cnt_q      <= ring_cnt_n;
            wait_cnt_q      <= wait_cnt_n;
            snooze_cnt_q    <= snooze_cnt_n;
            beep_q          <= beep_n;
            alarm_hours_q   <= alarm_hours_n;
            alarm_minutes_q <= alarm_minutes_n;
            ringing_q       <= (state_n == RINGING);
            buzzer_q        <= (state_n == RINGING) & beep_n;
            snooze_active_q <= (state_n == SNOOZE);
        end
    end

    assign bus.state         = state_q;
    assign bus.alarm_hours   = alarm_hours_q;
    assign bus.alarm_minutes = alarm_minutes_q;
    assign bus.ringing       = ringing_q;
    assign bus.buzzer        = buzzer_q;
    assign bus.snooze_active = snooze_active_q;

endmodule
